// File: rtl/bus_pkg.sv
// Shared definitions for the bit-serial master/slave port pair.
// Holds the mode encodings, the master FSM state type and the default
// address/data widths that both ends of the serial link agree on.
package bus_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        RWAIT = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/handshake_watchdog.sv
// Stall watchdog for the serial handshakes.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clear     - restart the count (a bit moved, or no transaction is active)
//   stall     - a cycle was spent waiting on the other side
//   expired   - this stall cycle is the TIMEOUT-th in a row; abort now
module handshake_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic stall,
    output logic expired
);

    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] cnt;

    // Saturating so the count can never wrap back to a small value.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (stall && (cnt != WW'(TIMEOUT))) begin
            cnt <= cnt + WW'(1);
        end
    end

    // Fires on the stall cycle that brings the count to TIMEOUT, so the FSM
    // leaves on that same edge rather than one cycle later.
    assign expired = stall && !clear && (cnt == WW'(TIMEOUT - 1));

endmodule

// File: rtl/serial_master_port.sv
// Bit-serial bus master. Takes one parallel read/write request, shifts the
// address (then write data) MSB-first onto wr_bus, and for reads collects
// DATA_WIDTH bits from rd_bus. One outstanding transaction; a one-cycle
// response pulse reports read data and timeout errors.
// Ports:
//   client side : req_valid/req_ready/req_mode/req_addr/req_wdata,
//                 rsp_valid/rsp_rdata/rsp_err, busy
//   serial side : mode, wr_bus, master_valid, slave_ready (write direction),
//                 rd_bus, slave_valid, master_ready (read direction)
module serial_master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_mode,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  mode,
    output logic                  wr_bus,
    output logic                  master_valid,
    output logic                  master_ready,
    input  logic                  rd_bus,
    input  logic                  slave_ready,
    input  logic                  slave_valid
);

    localparam int SW = ADDR_WIDTH + DATA_WIDTH;
    localparam int MW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(MW + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    state_t          state;
    logic [SW-1:0]   shreg;
    logic [CW-1:0]   bit_cnt;
    logic            wr_xfer, rd_xfer, wd_stall, wd_clear, expired;

    assign wr_xfer   = master_valid && slave_ready;
    assign rd_xfer   = slave_valid && master_ready;
    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    always_comb begin
        wd_stall = 1'b0;
        wd_clear = 1'b1;
        case (state)
            ADDR, WDATA: begin
                wd_stall = !wr_xfer;
                wd_clear = wr_xfer;
            end
            RWAIT, RDATA: begin
                wd_stall = !rd_xfer;
                wd_clear = rd_xfer;
            end
            default: ;
        endcase
    end

    handshake_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .stall   (wd_stall),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            mode         <= 1'b0;
            wr_bus       <= 1'b0;
            master_valid <= 1'b0;
            master_ready <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        // Address and write data share one shift register so
                        // the write-data MSB is already on top when the
                        // address runs out (no bubble between phases).
                        mode         <= req_mode;
                        shreg        <= {req_addr, req_wdata};
                        bit_cnt      <= '0;
                        wr_bus       <= req_addr[ADDR_WIDTH-1];
                        master_valid <= 1'b1;
                        state        <= ADDR;
                    end
                end
                ADDR, WDATA: begin
                    if (expired) begin
                        master_valid <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_err      <= 1'b1;
                        rsp_rdata    <= '0;
                        state        <= DONE;
                    end else if (wr_xfer) begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + CW'(1);
                        wr_bus  <= shreg[SW-2];
                        if (state == ADDR && bit_cnt == ADDR_LAST) begin
                            bit_cnt <= '0;
                            if (mode == MODE_WRITE) begin
                                state <= WDATA;
                            end else begin
                                master_valid <= 1'b0;
                                master_ready <= 1'b1;
                                state        <= RWAIT;
                            end
                        end else if (state == WDATA && bit_cnt == DATA_LAST) begin
                            master_valid <= 1'b0;
                            rsp_valid    <= 1'b1;
                            rsp_err      <= 1'b0;
                            rsp_rdata    <= '0;
                            state        <= DONE;
                        end
                    end
                end
                RWAIT, RDATA: begin
                    if (expired) begin
                        master_ready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_err      <= 1'b1;
                        rsp_rdata    <= '0;
                        state        <= DONE;
                    end else if (rd_xfer) begin
                        // Address bits have been shifted out, so the low
                        // bits are free to collect the read word.
                        shreg   <= {shreg[SW-2:0], rd_bus};
                        bit_cnt <= bit_cnt + CW'(1);
                        state   <= RDATA;
                        if (bit_cnt == DATA_LAST) begin
                            master_ready <= 1'b0;
                            rsp_valid    <= 1'b1;
                            rsp_err      <= 1'b0;
                            rsp_rdata    <= {shreg[DATA_WIDTH-2:0], rd_bus};
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_master_port.sv
module tb_serial_master_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_mode = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        mode;
    logic        wr_bus;
    logic        master_valid;
    logic        master_ready;
    logic        rd_bus = 1'b0;
    logic        slave_ready = 1'b0;
    logic        slave_valid = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    logic bits_q[$];
    int   tcyc_q[$];
    logic mode_q[$];

    serial_master_port #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .mode(mode), .wr_bus(wr_bus),
        .master_valid(master_valid), .master_ready(master_ready),
        .rd_bus(rd_bus), .slave_ready(slave_ready), .slave_valid(slave_valid)
    );

    always #5 clk = ~clk;

    // Bus monitor: records every write-direction bit that moves.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (master_valid && slave_ready) begin
            bits_q.push_back(wr_bus);
            tcyc_q.push_back(cyc);
            mode_q.push_back(mode);
        end
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    function automatic logic [47:0] q2v();
        logic [47:0] v = '0;
        for (int i = 0; i < bits_q.size(); i++) v = {v[46:0], bits_q[i]};
        return v;
    endfunction

    function automatic int count_modes(input logic m);
        int n = 0;
        for (int i = 0; i < mode_q.size(); i++) if (mode_q[i] === m) n++;
        return n;
    endfunction

    task automatic clear_mon();
        bits_q.delete(); tcyc_q.delete(); mode_q.delete();
    endtask

    // Called at a negedge with req_ready high; returns at the negedge after
    // the accepting edge.
    task automatic send_req(input logic m, input logic [15:0] a, input logic [7:0] d);
        req_valid = 1'b1; req_mode = m; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Waits at negedges for rsp_valid; n = negedges waited, or -1 on timeout.
    task automatic wait_rsp(input int limit, output int n);
        n = 0;
        while (!rsp_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, busy, master_valid, master_ready, rsp_valid, rsp_err, wr_bus, mode} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rr=%b busy=%b mv=%b mr=%b rv=%b err=%b wr=%b mode=%b, want all 0",
                     req_ready, busy, master_valid, master_ready, rsp_valid, rsp_err, wr_bus, mode);
        end
        checks++;
        if (rsp_rdata !== 8'h00) begin
            errors++; $display("FAIL reset_rdata: got %h want 00", rsp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_write_basic();
        int n;
        int ones;
        slave_ready = 1'b1;
        clear_mon();
        send_req(1'b1, 16'h0025, 8'hA5);
        wait_rsp(100, n);
        checks++;
        if (n < 0) begin
            errors++; $display("FAIL wr_rsp_timeout: got no rsp_valid want pulse");
        end
        checks++;
        if (bits_q.size() != 24 || q2v() !== 48'h0000_0000_25A5) begin
            errors++; $display("FAIL wr_bits: got %0d bits %h want 24 bits 0025a5", bits_q.size(), q2v());
        end
        checks++;
        if (bits_q.size() == 24 && (tcyc_q[23] - tcyc_q[0] != 23 || cyc != tcyc_q[23] + 1)) begin
            errors++; $display("FAIL wr_timing: got span %0d rsp_at +%0d want 23 and +1",
                               tcyc_q[23] - tcyc_q[0], cyc - tcyc_q[23]);
        end
        ones = count_modes(1'b1);
        checks++;
        if (ones != 24) begin
            errors++; $display("FAIL wr_mode: got %0d of 24 transfers with mode=1 want 24", ones);
        end
        checks++;
        if (rsp_err !== 1'b0 || rsp_rdata !== 8'h00 || master_valid !== 1'b0) begin
            errors++; $display("FAIL wr_rsp: got err=%b rdata=%h mv=%b want 0 00 0", rsp_err, rsp_rdata, master_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL wr_rsp_pulse: got rv=%b rr=%b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_read();
        int n;
        logic [7:0] rdat;
        rdat = 8'h3C;
        slave_ready = 1'b1;
        // rd_bus activity during the address phase must be ignored.
        slave_valid = 1'b1; rd_bus = 1'b1;
        clear_mon();
        send_req(1'b0, 16'h0025, 8'hFF);
        n = 0;
        while (!master_ready && n < 100) begin
            @(negedge clk); n++;
        end
        slave_valid = 1'b0; rd_bus = 1'b0;
        checks++;
        if (master_ready !== 1'b1 || master_valid !== 1'b0 || bits_q.size() != 16 || q2v() !== 48'h0025) begin
            errors++; $display("FAIL rd_addr: got mr=%b mv=%b %0d bits %h want 1 0 16 bits 0025",
                               master_ready, master_valid, bits_q.size(), q2v());
        end
        repeat (3) @(negedge clk);
        checks++;
        if (master_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rd_idle_wait: got mr=%b rv=%b want 1 0", master_ready, rsp_valid);
        end
        for (int i = 7; i >= 0; i--) begin
            slave_valid = 1'b1; rd_bus = rdat[i];
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (master_ready !== 1'b1 || rsp_valid !== 1'b0) begin
                    errors++; $display("FAIL rd_mid: got mr=%b rv=%b want 1 0", master_ready, rsp_valid);
                end
            end
        end
        slave_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C || rsp_err !== 1'b0 || master_ready !== 1'b0) begin
            errors++; $display("FAIL rd_rsp: got rv=%b rdata=%h err=%b mr=%b want 1 3c 0 0",
                               rsp_valid, rsp_rdata, rsp_err, master_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_write_alt();
        int k;
        slave_ready = 1'b0;
        clear_mon();
        send_req(1'b1, 16'h0025, 8'hA5);
        k = 0;
        while (!rsp_valid && k < 200) begin
            slave_ready = (k % 2 == 0);
            @(negedge clk);
            k++;
        end
        slave_ready = 1'b1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL alt_rsp: got rv=%b err=%b want 1 0", rsp_valid, rsp_err);
        end
        checks++;
        if (bits_q.size() != 24 || q2v() !== 48'h25A5) begin
            errors++; $display("FAIL alt_bits: got %0d bits %h want 24 bits 0025a5", bits_q.size(), q2v());
        end
        checks++;
        if (bits_q.size() == 24 && tcyc_q[23] - tcyc_q[0] + 1 != 47) begin
            errors++; $display("FAIL alt_cycles: got %0d want 47", tcyc_q[23] - tcyc_q[0] + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        slave_ready = 1'b0;
        clear_mon();
        send_req(1'b0, 16'h0025, 8'h00);
        wait_rsp(200, n);
        checks++;
        if (n != 64) begin
            errors++; $display("FAIL to_latency: got %0d want 64", n);
        end
        checks++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 8'h00 || master_valid !== 1'b0 || master_ready !== 1'b0
            || bits_q.size() != 0) begin
            errors++; $display("FAIL to_rsp: got err=%b rdata=%h mv=%b mr=%b bits=%0d want 1 00 0 0 0",
                               rsp_err, rsp_rdata, master_valid, master_ready, bits_q.size());
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL to_ready: got rv=%b rr=%b want 0 1", rsp_valid, req_ready);
        end
        slave_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n;
        int rc;
        slave_ready = 1'b1;
        clear_mon();
        send_req(1'b0, 16'h8421, 8'h00);
        repeat (8) @(negedge clk);
        checks++;
        if (bits_q.size() != 8) begin
            errors++; $display("FAIL rm_bits_before: got %0d want 8", bits_q.size());
        end
        rc = rsp_cnt;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (master_valid !== 1'b0 || master_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL rm_reset: got mv=%b mr=%b busy=%b rv=%b rr=%b want 0 0 0 0 0",
                               master_valid, master_ready, busy, rsp_valid, req_ready);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_cnt != rc || busy !== 1'b0) begin
            errors++; $display("FAIL rm_no_rsp: got %0d extra responses busy=%b want 0 0", rsp_cnt - rc, busy);
        end
        clear_mon();
        send_req(1'b1, 16'h0001, 8'hFF);
        wait_rsp(100, n);
        checks++;
        if (n < 0 || rsp_err !== 1'b0 || bits_q.size() != 24 || q2v() !== 48'h0001FF) begin
            errors++; $display("FAIL rm_after_write: got wait=%0d err=%b %0d bits %h want ok 0 24 bits 0001ff",
                               n, rsp_err, bits_q.size(), q2v());
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        slave_ready = 1'b1;
        clear_mon();
        req_valid = 1'b1; req_mode = 1'b1; req_addr = 16'h1234; req_wdata = 8'h5A;
        @(negedge clk);
        req_addr = 16'h00F0; req_wdata = 8'h3C;
        wait_rsp(100, n);
        checks++;
        if (n < 0 || master_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_first: got wait=%0d mv=%b want ok 0", n, master_valid);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || master_valid !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_gap: got rr=%b busy=%b mv=%b rv=%b want 1 0 0 0",
                               req_ready, busy, master_valid, rsp_valid);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || master_valid !== 1'b1 || wr_bus !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: got busy=%b mv=%b wr=%b want 1 1 0", busy, master_valid, wr_bus);
        end
        wait_rsp(100, n);
        checks++;
        if (n < 0 || rsp_err !== 1'b0 || bits_q.size() != 48 || q2v() !== 48'h12345A_00F03C) begin
            errors++; $display("FAIL b2b_bits: got wait=%0d err=%b %0d bits %h want ok 0 48 bits 12345a00f03c",
                               n, rsp_err, bits_q.size(), q2v());
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read();
        test_write_alt();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
